// File: rtl/vcmd_pkg.sv
// Shared opcode and state definitions for the pixel-command decoder.
// Imported by vcmd_stream and vcmd_fifo.
package vcmd_pkg;

  localparam logic [1:0] OP_SETADDR = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_BURST   = 2'b10;
  localparam logic [1:0] OP_NOP     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

endpackage

// File: rtl/vcmd_fifo.sv
// Show-ahead synchronous FIFO; head is on rdata whenever empty is low.
// Ports: Clk, RstN, push/wdata, pop, rdata, full, empty.
module vcmd_fifo
  import vcmd_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         Clk,
  input  logic         RstN,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wp, rp;
  logic [W-1:0] mem [DEPTH];
  logic         do_push, do_pop;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head forced to zero when empty so the outputs read 0 after reset.
  assign rdata = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vcmd_stream.sv
// Byte-stream pixel-command decoder: SETADDR / WRITE / BURST / NOP into a FIFO.
// Ports: Clk, RstN, CmdRecv/CmdIn in; MemAddr/MemData/MemValid/MemReady out; Busy, Overflow, Timeout, ClrErr.
module vcmd_stream
  import vcmd_pkg::*;
#(
  parameter int ADDR_W     = 19,
  parameter int DATA_BYTES = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    Clk,
  input  logic                    RstN,
  input  logic                    CmdRecv,
  input  logic [7:0]              CmdIn,
  output logic [ADDR_W-1:0]       MemAddr,
  output logic [8*DATA_BYTES-1:0] MemData,
  output logic                    MemValid,
  input  logic                    MemReady,
  output logic                    Busy,
  output logic                    Overflow,
  output logic                    Timeout,
  input  logic                    ClrErr
);

  localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int MAXB  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int IDX_W = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int SH_W  = 8 * MAXB;
  localparam int DW    = 8 * DATA_BYTES;
  localparam int FW    = ADDR_W + DW;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] A_LAST = IDX_W'(ADDR_BYTES - 1);
  localparam logic [IDX_W-1:0] D_LAST = IDX_W'(DATA_BYTES - 1);
  localparam logic [TW-1:0]    T_LAST = TW'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [6:0]        words;
  logic              burst;
  logic [ADDR_W-1:0] ptr;
  logic [SH_W-9:0]   shreg;
  logic [SH_W-1:0]   sh_cat;
  logic [TW-1:0]     idle_cnt;
  logic              tmo, addr_done, word_done;
  logic              full, empty, pop, push_ok;
  logic [FW-1:0]     head;

  // Earlier bytes sit above the byte arriving now, so MSB-first falls out.
  assign sh_cat = {shreg, CmdIn};

  assign MemValid = !empty;
  assign pop      = MemValid && MemReady;
  assign push_ok  = !full || pop;
  assign MemAddr  = head[FW-1:DW];
  assign MemData  = head[DW-1:0];
  assign Busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    tmo       = 1'b0;
    addr_done = 1'b0;
    word_done = 1'b0;
    // A strobe in the expiry cycle wins over the timeout.
    if (Busy && !CmdRecv && idle_cnt == T_LAST) begin
      tmo       = 1'b1;
      state_nxt = ST_IDLE;
    end else if (CmdRecv) begin
      unique case (state)
        ST_IDLE: begin
          unique case (1'b1)
            CmdIn[7:6] == OP_SETADDR: state_nxt = ST_ADDR;
            CmdIn[7:6] == OP_WRITE:   state_nxt = ST_DATA;
            CmdIn[7:6] == OP_BURST:   state_nxt = ST_DATA;
            CmdIn[7:6] == OP_NOP:     state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
          endcase
        end
        ST_ADDR: begin
          if (idx == A_LAST) begin
            addr_done = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (idx == D_LAST) begin
            word_done = 1'b1;
            if (words == 7'd1) state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      idx      <= '0;
      words    <= '0;
      burst    <= 1'b0;
      ptr      <= '0;
      shreg    <= '0;
      idle_cnt <= '0;
      Overflow <= 1'b0;
      Timeout  <= 1'b0;
    end else begin
      if (state_nxt == ST_IDLE || CmdRecv) idle_cnt <= '0;
      else                                 idle_cnt <= idle_cnt + 1'b1;

      if (CmdRecv) shreg <= sh_cat[SH_W-9:0];

      if (tmo) begin
        idx <= '0;
      end else if (CmdRecv) begin
        unique case (state)
          ST_IDLE: begin
            idx <= '0;
            if (CmdIn[7:6] == OP_WRITE) begin
              words <= 7'd1;
              burst <= 1'b0;
            end else if (CmdIn[7:6] == OP_BURST) begin
              words <= {1'b0, CmdIn[5:0]} + 7'd1;
              burst <= 1'b1;
            end
          end
          ST_ADDR: begin
            idx <= addr_done ? '0 : idx + 1'b1;
            if (addr_done) ptr <= sh_cat[ADDR_W-1:0];
          end
          ST_DATA: begin
            idx <= word_done ? '0 : idx + 1'b1;
            // Dropped words still advance the pointer to keep burst alignment.
            if (word_done) begin
              words <= words - 7'd1;
              if (burst) ptr <= ptr + 1'b1;
            end
          end
          default: idx <= '0;
        endcase
      end

      if (word_done && !push_ok) Overflow <= 1'b1;
      else if (ClrErr)           Overflow <= 1'b0;

      if (tmo)         Timeout <= 1'b1;
      else if (ClrErr) Timeout <= 1'b0;
    end
  end

  vcmd_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .RstN  (RstN),
    .push  (word_done),
    .wdata ({ptr, sh_cat[DW-1:0]}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: doc/vcmd_stream.md
# vcmd_stream

Parametrised pixel-command decoder, successor to the single-write `vcmd` path. Sits between the SPI byte receiver and the frame-memory write port, all in one clock domain. Parses a byte stream into:
- address-set commands,
- single writes,
- auto-incrementing burst writes.

Completed words are buffered in a small FIFO with valid/ready handshake. Adds overflow detection and inter-byte timeout recovery.

## Interface
- `ADDR_W`, 19, memory address width; `ADDR_BYTES = (ADDR_W+7)/8`
- `DATA_BYTES`, 3, bytes per pixel word; `MemData` width `8*DATA_BYTES`
- `FIFO_DEPTH`, 4, output FIFO entries, power of two, ≥2
- `TIMEOUT`, 1024, idle clocks mid-command before abort, ≥2
- `Clk  in  1  system clock`
- `RstN  in  1  asynchronous, active-low reset`
- `CmdRecv  in  1  one-cycle strobe, CmdIn valid; already synchronised to Clk`
- `CmdIn  in  8  received byte`
- `MemAddr  out  ADDR_W  head-of-FIFO address`
- `MemData  out  8*DATA_BYTES  head-of-FIFO data, first-received byte in MSBs`
- `MemValid  out  1  FIFO non-empty`
- `MemReady  in  1  consumer accepts head when MemValid & MemReady`
- `Busy  out  1  decoder not in IDLE`
- `Overflow  out  1  sticky: word dropped, FIFO full`
- `Timeout  out  1  sticky: command aborted by timeout`
- `ClrErr  in  1  clears Overflow and Timeout`

## Operation
- Opcode is `CmdIn[7:6]` of the first byte in IDLE:
  - `00` SETADDR: next `ADDR_BYTES` bytes, MSB first, shifted into a staging register. The address pointer loads the low `ADDR_W` bits after the last byte.
  - `01` WRITE: next `DATA_BYTES` bytes form one word, pushed at the pointer. Pointer unchanged. `CmdIn[5:0]` ignored.
  - `10` BURST: `CmdIn[5:0]+1` words (1..64), each `DATA_BYTES` bytes. Each word is pushed at the pointer, then the pointer increments by 1 modulo `2**ADDR_W`.
  - `11` NOP: single byte, no effect.
- States:
  - IDLE → ADDR on `00`; IDLE → DATA on `01`/`10`.
  - ADDR → IDLE after the last address byte.
  - DATA → IDLE after the last byte of the last word.
  - ADDR/DATA → IDLE on timeout.
- Counters:
  - byte index, 0..max(`ADDR_BYTES`,`DATA_BYTES`)−1;
  - words remaining, 7 bits.
- Full FIFO at word completion:
  - the word is dropped and `Overflow` is set;
  - the pointer still advances, keeping burst alignment.
- Push on a full FIFO is accepted if a pop occurs in the same cycle.
- Timeout:
  - An idle counter runs while not in IDLE and resets on every `CmdRecv`. Reaching `TIMEOUT` forces IDLE and sets `Timeout`.
  - Any partial word or partial address is discarded.
  - Words already pushed and pointer advances already made stand.
  - `CmdRecv` in the expiry cycle wins: the byte is processed and the counter resets.
- `ClrErr` concurrent with a new error event: the flag stays set.
- Reset values:
  - all outputs 0;
  - pointer 0, FIFO empty, state IDLE, counters 0.
- Reset mid-command discards everything, including FIFO contents.

## Timing
- Final byte of a word is sampled at edge k. The FIFO is written at edge k, so `MemValid`/`MemAddr`/`MemData` are valid after edge k (one-cycle latency, show-ahead FIFO).
- Pop occurs at the edge where `MemValid & MemReady`. The next head is visible after that edge.
- `Busy` rises after the edge sampling the opcode byte. It falls after the edge sampling the final byte, or at timeout.
- SETADDR followed immediately by WRITE uses the new pointer (it is loaded at the final address byte edge).
- Back-to-back `CmdRecv` on consecutive cycles is legal. Throughput is one byte per clock.
- `Overflow`/`Timeout` are set at the edge of the event. They clear at the `ClrErr` edge.

## Structure
- Shared package `vcmd_pkg`:
  - opcode constants `OP_SETADDR`, `OP_WRITE`, `OP_BURST`, `OP_NOP`;
  - state encoding `ST_IDLE`, `ST_ADDR`, `ST_DATA`.
- Sub-module `vcmd_fifo`: synchronous show-ahead FIFO.
  - Parameters: width `ADDR_W+8*DATA_BYTES`, `FIFO_DEPTH`.
  - Ports: push/pop/full/empty, same `Clk`/`RstN`.
- Top holds the decoder FSM, counters, pointer, timeout counter and sticky flags.

## Test plan
All scenarios use defaults unless noted.
- SETADDR: bytes 0x00,0x01,0x23,0x45, then WRITE: 0x41,0xC0,0xC0,0xC0. Expect one word: `MemAddr`=0x12345, `MemData`=0xC0C0C0, one cycle after the last strobe. `Busy` 0 afterwards.
- From pointer 0x12345, BURST 0x81 with bytes 0x01..0x06. Expect words (0x12345,0x010203) then (0x12346,0x040506); pointer ends at 0x12347.
- SETADDR to 0x7FFFF (bytes 0x07,0xFF,0xFF), then BURST 0x81 with 6 bytes. Expect addresses 0x7FFFF then 0x00000 (wrap).
- Overflow: `MemReady`=0, BURST 0x84 (5 words).
  - Expect 4 entries held, `Overflow`=1, fifth word absent, pointer +5.
  - Then raise `MemReady`: expect 4 pops in order.
  - Then pulse `ClrErr`: expect `Overflow`=0.
- Timeout: WRITE plus 2 data bytes, then `TIMEOUT` idle clocks.
  - Expect `Timeout`=1, `Busy`=0, no word pushed.
  - A following NOP then WRITE decodes normally.
  - `CmdRecv` exactly at the expiry cycle: no timeout.
- Assert `RstN` low mid-BURST with 2 words queued. Expect FIFO empty, all outputs 0, pointer 0; decoding restarts cleanly from IDLE.
